jkff_bank_arbiter: RTL and testbench

Round-robin command arbiter and sequencer for a bank of WIDTH `jkff_sync_reset` flip-flops shared by NREQ requesters. Each requester can ask for one operation on one bit: reset, set, clear or toggle. The block grants one request at a time, drives that flop's J/K/syncReset inputs for exactly one clock, then reads the flop's Q back and reports completion plus a pass/fail check. The flop bank sits outside this block; its Q outputs return on `qIn`.

---
 rtl/jkff_bank_arbiter.sv | 159 +++++++++++++++
 tb/tb_jkff_bank_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jkff_bank_arbiter.sv
// Round-robin command arbiter for a bank of J/K flops with synchronous reset.
// One granted request at a time: drive the target flop for one clock, then
// read its Q back and report completion with a pass/fail check.
//
// Handshake: a requester holds req/op/idx stable until its one-cycle gnt pulse
// and drops req no later than its one-cycle done pulse; a req still high in
// IDLE is treated as a new request.
module jkff_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 asyncReset,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IW*NREQ-1:0]   idx,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 rdData,
  output logic                 err,
  output logic                 busy,
  output logic [WIDTH-1:0]     jVec,
  output logic [WIDTH-1:0]     kVec,
  output logic [WIDTH-1:0]     syncResetVec,
  input  logic [WIDTH-1:0]     qIn
);

  localparam int PW = $clog2(NREQ);

  localparam logic [1:0] OP_RESET  = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t          state;
  state_t          stateNext;
  logic            grantNow;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic [IW-1:0]   curIdx;
  logic            curValid;
  logic            expected;

  logic            found;
  logic [PW-1:0]   selNum;
  logic [1:0]      selOp;
  logic [IW-1:0]   selIdx;
  logic            selValid;
  logic [WIDTH-1:0] selBit;
  logic            selExpect;
  logic [PW-1:0]   nextPtr;

  assign busy = (state != IDLE);

  // Round-robin search starting at ptr, plus decode of the winner's command.
  always_comb begin
    found  = 1'b0;
    selNum = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found  = 1'b1;
        selNum = PW'((int'(ptr) + k) % NREQ);
      end
    end
    selOp    = op[2*int'(selNum) +: 2];
    selIdx   = idx[IW*int'(selNum) +: IW];
    selValid = (int'(selIdx) < WIDTH);
    selBit   = selValid ? (WIDTH'(1) << selIdx) : '0;
    // Toggle expects the inverse of the value seen at grant time.
    case (selOp)
      OP_SET:    selExpect = 1'b1;
      OP_TOGGLE: selExpect = selValid ? ~qIn[selIdx] : 1'b0;
      default:   selExpect = 1'b0;
    endcase
    nextPtr = (int'(selNum) == NREQ - 1) ? '0 : selNum + 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge asyncReset) begin
    if (asyncReset) state <= IDLE;
    else            state <= stateNext;
  end

  // Next-state logic: IDLE grants on any request, DRIVE and CHECK last one cycle.
  always_comb begin
    stateNext = state;
    grantNow  = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          grantNow  = 1'b1;
          stateNext = DRIVE;
        end
      end
      DRIVE:   stateNext = CHECK;
      CHECK:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Command capture, one-cycle drive pulse, and read-back check.
  always_ff @(posedge clk or posedge asyncReset) begin
    if (asyncReset) begin
      ptr          <= '0;
      winner       <= '0;
      curIdx       <= '0;
      curValid     <= 1'b0;
      expected     <= 1'b0;
      gnt          <= '0;
      done         <= '0;
      rdData       <= 1'b0;
      err          <= 1'b0;
      jVec         <= '0;
      kVec         <= '0;
      syncResetVec <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      if (grantNow) begin
        winner   <= selNum;
        curIdx   <= selIdx;
        curValid <= selValid;
        expected <= selExpect;
        gnt      <= NREQ'(1) << selNum;
        ptr      <= nextPtr;
        // A bad index still gets a grant but selBit is zero, so nothing drives.
        case (selOp)
          OP_RESET:  syncResetVec <= selBit;
          OP_SET:    jVec         <= selBit;
          OP_CLEAR:  kVec         <= selBit;
          default: begin
            jVec <= selBit;
            kVec <= selBit;
          end
        endcase
      end
      if (state == DRIVE) begin
        jVec         <= '0;
        kVec         <= '0;
        syncResetVec <= '0;
      end
      if (state == CHECK) begin
        done[winner] <= 1'b1;
        if (curValid) begin
          rdData <= qIn[curIdx];
          err    <= (qIn[curIdx] != expected);
        end else begin
          rdData <= 1'b0;
          err    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jkff_bank_arbiter.sv
// Bench for jkff_bank_arbiter: a behavioural J/K flop bank closes the loop,
// a high-level model predicts grant order and results into queues, and a
// monitor compares every grant and completion the DUT presents.
module tb_jkff_bank_arbiter;

  localparam int WIDTH = 6;
  localparam int NREQ  = 4;
  localparam int IW    = 3;
  localparam int GW    = NREQ + 3*WIDTH;
  localparam int DW    = NREQ + 2;

  logic                clk = 1'b0;
  logic                asyncReset;
  logic [NREQ-1:0]     req;
  logic [2*NREQ-1:0]   op;
  logic [IW*NREQ-1:0]  idx;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     done;
  logic                rdData;
  logic                err;
  logic                busy;
  logic [WIDTH-1:0]    jVec;
  logic [WIDTH-1:0]    kVec;
  logic [WIDTH-1:0]    syncResetVec;
  logic [WIDTH-1:0]    qIn;

  logic [WIDTH-1:0]    bank = '0;
  logic [WIDTH-1:0]    forceMask;

  logic [GW-1:0]       gnt_q[$];
  logic [DW-1:0]       exp_q[$];
  int                  checks = 0;
  int                  errors = 0;
  int                  cyc = 0;
  int                  lastGntCyc = 0;

  logic [WIDTH-1:0]    mq;
  int                  mPtr;
  logic [1:0]          bOp[NREQ];
  logic [IW-1:0]       bIdx[NREQ];

  jkff_bank_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IW(IW)) dut (
    .clk(clk), .asyncReset(asyncReset), .req(req), .op(op), .idx(idx),
    .gnt(gnt), .done(done), .rdData(rdData), .err(err), .busy(busy),
    .jVec(jVec), .kVec(kVec), .syncResetVec(syncResetVec), .qIn(qIn)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural flop bank; forceMask pins selected Q lines low.
  always @(posedge clk) begin
    for (int b = 0; b < WIDTH; b++) begin
      if (syncResetVec[b]) bank[b] <= 1'b0;
      else case ({jVec[b], kVec[b]})
        2'b10:   bank[b] <= 1'b1;
        2'b01:   bank[b] <= 1'b0;
        2'b11:   bank[b] <= ~bank[b];
        default: bank[b] <= bank[b];
      endcase
    end
  end
  assign qIn = bank & ~forceMask;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  // Model: serve the pending set in round-robin order from mPtr, applying
  // each command to the modelled bank and queueing expected grant/done.
  task automatic model_predict(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0]  pend;
    logic [NREQ-1:0]  oh;
    logic [WIDTH-1:0] jj, kk, ss;
    logic             oldSeen, newq, expv, rd, er;
    int               w, ix;
    pend = mask;
    while (pend != 0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && pend[(mPtr + k) % NREQ]) w = (mPtr + k) % NREQ;
      ix = int'(bIdx[w]);
      jj = '0; kk = '0; ss = '0;
      if (ix >= WIDTH) begin
        rd = 1'b0;
        er = 1'b1;
      end else begin
        oldSeen = mq[ix] & ~forceMask[ix];
        case (bOp[w])
          2'b00: begin newq = 1'b0;    expv = 1'b0;     ss[ix] = 1'b1; end
          2'b01: begin newq = 1'b1;    expv = 1'b1;     jj[ix] = 1'b1; end
          2'b10: begin newq = 1'b0;    expv = 1'b0;     kk[ix] = 1'b1; end
          default: begin newq = ~mq[ix]; expv = ~oldSeen; jj[ix] = 1'b1; kk[ix] = 1'b1; end
        endcase
        mq[ix] = newq;
        rd = newq & ~forceMask[ix];
        er = (rd != expv);
      end
      oh = '0;
      oh[w] = 1'b1;
      gnt_q.push_back({oh, jj, kk, ss});
      exp_q.push_back({oh, rd, er});
      pend[w] = 1'b0;
      mPtr = (w + 1) % NREQ;
    end
  endtask

  // Driver: raise a set of requests together, drop each on its grant.
  task automatic run_batch(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] pendHw;
    int waited, prevCyc;
    model_predict(mask);
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      op[2*i +: 2]   = mask[i] ? bOp[i] : 2'b00;
      idx[IW*i +: IW] = mask[i] ? bIdx[i] : '0;
    end
    req = mask;
    pendHw = mask;
    waited = 0;
    prevCyc = -1;
    while (pendHw != 0 && waited < 12*NREQ) begin
      @(negedge clk);
      waited++;
      if (waited == 1) check("grant_latency", 64'(|gnt), 64'(1));
      if ((gnt & pendHw) != 0) begin
        if (prevCyc >= 0) check("grant_spacing", 64'(cyc - prevCyc), 64'(3));
        prevCyc = cyc;
        req    = req & ~gnt;
        pendHw = pendHw & ~gnt;
      end
    end
    if (pendHw != 0) begin
      checks++;
      errors++;
      $display("FAIL batch_timeout pending=%0h required=0", pendHw);
      req = '0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic set_cmd(input int i, input logic [1:0] o, input logic [IW-1:0] ix);
    bOp[i]  = o;
    bIdx[i] = ix;
  endtask

  // Monitor / scoreboard: compare every grant and completion against the queues.
  always @(negedge clk) begin
    logic [GW-1:0] eg;
    logic [DW-1:0] ed;
    if (gnt != 0) begin
      if (gnt_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant actual=%0h required=none", gnt);
      end else begin
        eg = gnt_q.pop_front();
        check("grant_drive", 64'({gnt, jVec, kVec, syncResetVec}), 64'(eg));
      end
      check("busy_at_grant", 64'(busy), 64'(1));
      lastGntCyc = cyc;
    end else begin
      check("drive_idle", 64'({jVec, kVec, syncResetVec}), 64'(0));
    end
    if (done != 0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%0h required=none", done);
      end else begin
        ed = exp_q.pop_front();
        check("done_result", 64'({done, rdData, err}), 64'(ed));
      end
      check("grant_to_done", 64'(cyc - lastGntCyc), 64'(2));
      check("busy_at_done", 64'(busy), 64'(0));
    end
  end

  initial begin
    logic [WIDTH-1:0] jj;
    logic [NREQ-1:0]  oh;
    int w;
    logic sawDone;
    asyncReset = 1'b1;
    req = '0; op = '0; idx = '0;
    forceMask = '0;
    mq = '0;
    mPtr = 0;
    for (int i = 0; i < NREQ; i++) set_cmd(i, 2'b00, '0);
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({gnt, done, rdData, err, busy}), 64'(0));
    check("reset_drive", 64'({jVec, kVec, syncResetVec}), 64'(0));
    asyncReset = 1'b0;
    @(negedge clk);

    // set then read, then toggle
    set_cmd(0, 2'b01, 3'd3);
    run_batch(4'b0001);
    set_cmd(2, 2'b11, 3'd3);
    run_batch(4'b0100);

    // round-robin with all four requesters, then re-raise all
    for (int i = 0; i < NREQ; i++) set_cmd(i, 2'b01, IW'(i));
    run_batch(4'b1111);
    check("rr_final_q", 64'(qIn), 64'(6'h0F));
    run_batch(4'b1111);

    // reset op, then bad index
    set_cmd(1, 2'b00, 3'd3);
    run_batch(4'b0010);
    set_cmd(3, 2'b01, 3'd7);
    run_batch(4'b1000);

    // forced mismatch on bit 5
    forceMask = 6'h20;
    set_cmd(0, 2'b01, 3'd5);
    run_batch(4'b0001);
    forceMask = '0;

    // async reset during DRIVE
    @(negedge clk);
    op[4 +: 2] = 2'b01;
    idx[6 +: 3] = 3'd4;
    req = 4'b0100;
    jj = 6'b010000;
    oh = 4'b0100;
    gnt_q.push_back({oh, jj, {WIDTH{1'b0}}, {WIDTH{1'b0}}});
    w = 0;
    while (gnt == 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("abort_grant_seen", 64'(gnt), 64'(4'b0100));
    #1 asyncReset = 1'b1;
    #1;
    check("abort_drive_cleared", 64'({jVec, kVec, syncResetVec}), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    req = '0;
    @(negedge clk);
    asyncReset = 1'b0;
    mPtr = 0;
    sawDone = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done != 0) sawDone = 1'b1;
    end
    check("abort_no_done", 64'(sawDone), 64'(0));
    check("abort_bank", 64'(qIn), 64'(mq));
    for (int i = 0; i < NREQ; i++) set_cmd(i, 2'b10, IW'(i));
    run_batch(4'b1111);

    // randomized batches, including out-of-range indices
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_cmd(i, 2'($urandom_range(0, 3)), IW'($urandom_range(0, 7)));
      run_batch(NREQ'($urandom_range(1, 15)));
    end

    check("final_bank", 64'(qIn), 64'(mq));
    check("queues_drained", 64'(gnt_q.size() + exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
